// File: rtl/mem_pkg.sv
// Shared types and widths for the load/store memory stage.
// ASIZE/DSIZE supply the default address/data widths.
`ifndef ASIZE
`define ASIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

package mem_pkg;
  localparam int TAG_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter with asynchronous active-low clear.
module sat_cnt import mem_pkg::*; (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n)  r_cnt <= '0;
    else if (i_en) r_cnt <= sat_inc(r_cnt);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: one outstanding load/store at a time to a registered-read data memory.
// Define MEM_ADDR_CHECK_EN to fault out-of-range addresses instead of issuing them.
module mem_stage import mem_pkg::*; #(
  parameter int AW        = `ASIZE,
  parameter int DW        = `DSIZE,
  parameter int MEM_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [TAG_W-1:0] req_rd,
  output logic             dm_ren,
  output logic             dm_wen,
  output logic [AW-1:0]    dm_addr,
  output logic [DW-1:0]    dm_wdata,
  input  logic [DW-1:0]    dm_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             rsp_is_load,
  output logic             rsp_fault,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt
);
  state_t           r_state;
  logic             r_ren, r_wen, r_rsp_valid, r_is_load;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata, r_rsp_data;
  logic [TAG_W-1:0] r_rsp_rd;
  logic             w_hs;

`ifdef MEM_ADDR_CHECK_EN
  logic r_fault;
  logic w_oob;
  assign w_oob     = 32'(req_addr) >= 32'(MEM_WORDS);
  assign rsp_fault = r_fault;
`else
  assign rsp_fault = 1'b0;
`endif

  // Gated by rst so the stage never advertises readiness while held in reset.
  assign req_ready = rst && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_rd    <= '0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef MEM_ADDR_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr     <= req_addr;
          r_rsp_rd   <= req_rd;
          r_is_load  <= !req_we;
          r_rsp_data <= '0;
          if (req_we) r_wdata <= req_wdata;
`ifdef MEM_ADDR_CHECK_EN
          r_fault    <= w_oob;
          if (w_oob) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else
`endif
          if (req_we) begin
            r_state <= S_WR;
            r_wen   <= 1'b1;
          end else begin
            r_state <= S_RD;
            r_ren   <= 1'b1;
          end
        end
        S_RD: begin
          r_ren   <= 1'b0;
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_rsp_data  <= dm_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_WR: begin
          r_wen       <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dm_ren      = r_ren;
  assign dm_wen      = r_wen;
  assign dm_addr     = r_addr;
  assign dm_wdata    = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_is_load = r_is_load;

  // Faulted accesses complete the handshake but are not counted.
  assign w_hs = r_rsp_valid && rsp_ready && !rsp_fault;

  sat_cnt u_ld_cnt (.i_clk(clk), .i_clr_n(rst), .i_en(w_hs &&  r_is_load), .o_cnt(ld_cnt));
  sat_cnt u_st_cnt (.i_clk(clk), .i_clr_n(rst), .i_en(w_hs && !r_is_load), .o_cnt(st_cnt));
endmodule
